// File: rtl/dummy_pos_sched_pkg.sv
// Shared types and constants for the dummy-position scheduler: FSM states,
// LFSR feedback taps, default geometry and the Galois step function.
package dummy_pos_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int DEF_N          = 17669;
    localparam int DEF_WEIGHT     = 66;
    localparam int DEF_MAX_WEIGHT = 75;

    // Right-shifting Galois step: the bit leaving position 0 folds the taps back in.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with same-cycle seed load; value_o shows the loaded seed immediately.
// Latency: load visible combinationally, advance takes effect next cycle. Built only with DUMMY_INSERT_EN.
`ifdef DUMMY_INSERT_EN
module lfsr32_galois
    import dummy_pos_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic [31:0] value_o
);

    logic [31:0] state_q, state_d;
    logic [31:0] cur;

    // An all-zero seed would lock the register, so it is replaced by 1.
    always_comb begin
        cur = state_q;
        if (load_i) begin
            cur = (seed_i == 32'h0) ? 32'h0000_0001 : seed_i;
        end
        state_d = adv_i ? lfsr_step(cur) : cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 32'h0000_0001;
        end else begin
            state_q <= state_d;
        end
    end

    assign value_o = cur;

endmodule
`endif

// File: rtl/dummy_pos_sched.sv
// Emits WEIGHT real positions (read from external RAM in index order) interleaved with
// LFSR-chosen dummy positions; real slot 3 cycles, dummy 1 cycle; holds outputs while out_ready_i=0.
// Dummy insertion is compiled in only when DUMMY_INSERT_EN is defined.
module dummy_pos_sched
    import dummy_pos_sched_pkg::*;
#(
    parameter int MAX_WEIGHT = DEF_MAX_WEIGHT,
    parameter int WEIGHT     = DEF_WEIGHT,
    parameter int N          = DEF_N,
    parameter int LOGW       = 16,
    parameter int LOGN       = 15,
    parameter int LOG_WEIGHT = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  busy_o,
    input  logic [31:0]           seed_i,
    input  logic                  seed_load_i,
    output logic [LOG_WEIGHT-1:0] pos_addr_o,
    input  logic [LOGW-1:0]       pos_rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LOGW-1:0]       out_pos_o,
    output logic                  out_dummy_o,
    output logic                  out_last_o,
    output logic                  done_o
);

    localparam int CW = LOG_WEIGHT + 1;
    localparam logic [CW-1:0] R_INIT = CW'(WEIGHT);
`ifdef DUMMY_INSERT_EN
    localparam logic [CW-1:0] D_INIT = CW'(MAX_WEIGHT - WEIGHT);
`else
    localparam logic [CW-1:0] D_INIT = '0;
`endif

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  dummy_q, dummy_d;
    logic                  last_q, last_d;
    logic [LOGW-1:0]       pos_q, pos_d;
    logic [LOG_WEIGHT-1:0] addr_q, addr_d;
    logic [LOG_WEIGHT-1:0] ridx_q, ridx_d;
    logic [CW-1:0]         r_q, r_d;
    logic [CW-1:0]         d_q, d_d;

    logic                  hs;
    logic                  dec_go;
    logic                  dec_dummy;
    logic [CW-1:0]         dec_r, dec_d;
    logic [LOG_WEIGHT-1:0] dec_idx;
    logic                  rnd_bit;
    logic [LOGW-1:0]       rnd_pos;

`ifdef DUMMY_INSERT_EN
    logic                  seed_ld;
    logic [31:0]           lfsr_val;
    logic [LOGN-1:0]       rnd_raw;
    logic                  unused_lfsr_hi;

    // Seeds are only accepted while idle; a load alongside start feeds the first decision.
    assign seed_ld = seed_load_i && (state_q == IDLE);

    lfsr32_galois u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (seed_ld),
        .seed_i  (seed_i),
        .adv_i   (dec_go),
        .value_o (lfsr_val)
    );

    assign rnd_bit = lfsr_val[0];
    assign rnd_raw = lfsr_val[LOGN-1:0];
    // LOGN bits span less than 2N, so a single conditional subtract lands in [0, N).
    assign rnd_pos = (rnd_raw >= LOGN'(N)) ? LOGW'(rnd_raw - LOGN'(N)) : LOGW'(rnd_raw);
    assign unused_lfsr_hi = ^lfsr_val[31:LOGN];
`else
    logic unused_seed;

    assign rnd_bit     = 1'b0;
    assign rnd_pos     = '0;
    assign unused_seed = ^{seed_i, seed_load_i};
`endif

    assign hs = valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        dummy_d = dummy_q;
        last_d  = last_q;
        pos_d   = pos_q;
        addr_d  = addr_q;
        dec_go  = 1'b0;
        dec_r   = r_q;
        dec_d   = d_q;
        dec_idx = ridx_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    busy_d  = 1'b1;
                    dec_go  = 1'b1;
                    dec_r   = R_INIT;
                    dec_d   = D_INIT;
                    dec_idx = '0;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                pos_d   = pos_rd_data_i;
                valid_d = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    if (dummy_q) begin
                        dec_d = d_q - CW'(1);
                    end else begin
                        dec_r   = r_q - CW'(1);
                        dec_idx = ridx_q + LOG_WEIGHT'(1);
                    end
                    if (last_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        dec_go = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Slot decision, shared by schedule start and every non-final handshake.
        dec_dummy = (dec_d != '0) && ((dec_r == '0) || rnd_bit);
        if (dec_go) begin
            last_d = ((dec_r + dec_d) == CW'(1));
            if (dec_dummy) begin
                state_d = EMIT;
                valid_d = 1'b1;
                dummy_d = 1'b1;
                pos_d   = rnd_pos;
            end else begin
                state_d = FETCH;
                dummy_d = 1'b0;
                addr_d  = dec_idx;
            end
        end
    end

    assign r_d    = dec_r;
    assign d_d    = dec_d;
    assign ridx_d = dec_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            dummy_q <= 1'b0;
            last_q  <= 1'b0;
            pos_q   <= '0;
            addr_q  <= '0;
            ridx_q  <= '0;
            r_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            dummy_q <= dummy_d;
            last_q  <= last_d;
            pos_q   <= pos_d;
            addr_q  <= addr_d;
            ridx_q  <= ridx_d;
            r_q     <= r_d;
            d_q     <= d_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_valid_o = valid_q;
    assign out_dummy_o = dummy_q;
    assign out_last_o  = last_q;
    assign out_pos_o   = pos_q;
    assign pos_addr_o  = addr_q;

endmodule

// File: tb/tb_dummy_pos_sched.sv
// Scoreboard bench for dummy_pos_sched: runs push expected slots, a negedge monitor pops/compares.
module tb_dummy_pos_sched;

    localparam int WEIGHT = 66;
`ifdef DUMMY_INSERT_EN
    localparam int TOTAL = 75;
`else
    localparam int TOTAL = 66;
`endif
    localparam int NPOLY   = 17669;
    localparam int EXP_CYC = 3 * WEIGHT + (TOTAL - WEIGHT);

    typedef struct {
        logic [15:0] pos;
        logic        dummy;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        busy_o;
    logic [31:0] seed_i;
    logic        seed_load_i;
    logic [6:0]  pos_addr_o;
    logic [15:0] pos_rd_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_pos_o;
    logic        out_dummy_o;
    logic        out_last_o;
    logic        done_o;

    logic        toggle_en;
    logic        tgl;
    logic [15:0] ram_q;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   hs_count = 0;
    int   done_cnt = 0;
    int   valid_cnt = 0;

    bit          hold_vld = 0;
    logic [15:0] held_pos;
    logic        held_dummy;
    logic        held_last;

    always #5 clk = ~clk;

    assign out_ready_i = toggle_en ? tgl : 1'b1;

    // Synchronous-read RAM holding index+100.
    always @(posedge clk) ram_q <= 16'(pos_addr_o) + 16'd100;
    assign pos_rd_data_i = ram_q;

    dummy_pos_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .seed_i        (seed_i),
        .seed_load_i   (seed_load_i),
        .pos_addr_o    (pos_addr_o),
        .pos_rd_data_i (pos_rd_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_pos_o     (out_pos_o),
        .out_dummy_o   (out_dummy_o),
        .out_last_o    (out_last_o),
        .done_o        (done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void gen_expected(input logic [31:0] s);
        logic [31:0] l;
        logic [15:0] p;
        int r;
        int d;
        int idx;
        bit dm;
        bit lst;
        l   = (s == 32'h0) ? 32'h1 : s;
        r   = WEIGHT;
        d   = TOTAL - WEIGHT;
        idx = 0;
        exp_q.delete();
        for (int k = 0; k < TOTAL; k++) begin
            dm  = (d > 0) && ((r == 0) || l[0]);
            lst = (r + d) == 1;
            if (dm) begin
                p = {1'b0, l[14:0]};
                if (int'(p) >= NPOLY) p = p - 16'(NPOLY);
                exp_q.push_back('{pos: p, dummy: 1'b1, last: lst});
                d--;
            end else begin
                exp_q.push_back('{pos: 16'(100 + idx), dummy: 1'b0, last: lst});
                idx++;
                r--;
            end
            l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 0;
        end else begin
            if (hold_vld) begin
                chk("hold_valid", 32'(out_valid_o), 32'd1);
                chk("hold_pos", 32'(out_pos_o), 32'(held_pos));
                chk("hold_dummy", 32'(out_dummy_o), 32'(held_dummy));
                chk("hold_last", 32'(out_last_o), 32'(held_last));
            end
            if (out_valid_o) valid_cnt++;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("extra_slot", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("slot_pos", 32'(out_pos_o), 32'(e.pos));
                    chk("slot_dummy", 32'(out_dummy_o), 32'(e.dummy));
                    chk("slot_last", 32'(out_last_o), 32'(e.last));
                    if (out_dummy_o) chk("dummy_lt_n", 32'(int'(out_pos_o) < NPOLY), 32'd1);
                end
                hs_count++;
            end
            hold_vld   = out_valid_o && !out_ready_i;
            held_pos   = out_pos_o;
            held_dummy = out_dummy_o;
            held_last  = out_last_o;
            if (done_o) done_cnt++;
        end
    end

    initial begin
        tgl = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) tgl = ~tgl;
        end
    end

    task automatic run_sched(input logic [31:0] seed, input logic [31:0] model_seed,
                             input bit load_with_start, input int exp_cycles);
        int cyc;
        int done_before;
        bit got;
        gen_expected(model_seed);
        if (!load_with_start) begin
            seed_i = seed;
            seed_load_i = 1'b1;
            @(posedge clk);
            #1 seed_load_i = 1'b0;
        end
        seed_i      = seed;
        seed_load_i = load_with_start;
        start_i     = 1'b1;
        done_before = done_cnt;
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        seed_load_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        cyc = 0;
        got = 0;
        while (cyc < 3000 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_o) got = 1;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (exp_cycles > 0) chk("schedule_cycles", 32'(cyc), 32'(exp_cycles));
        chk("busy_in_done", 32'(busy_o), 32'd0);
        chk("valid_in_done", 32'(out_valid_o), 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(done_o), 32'd0);
        chk("slots_left", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt - done_before), 32'd1);
    endtask

    initial begin
        int base;
        int done_before;
        int valid_before;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        seed_i      = 32'h0;
        seed_load_i = 1'b0;
        toggle_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_dummy", 32'(out_dummy_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_pos", 32'(out_pos_o), 32'd0);
        chk("rst_addr", 32'(pos_addr_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_sched(32'h1, 32'h1, 1'b0, EXP_CYC);
        run_sched(32'h1, 32'h1, 1'b1, EXP_CYC);
        run_sched(32'h2, 32'h2, 1'b0, EXP_CYC);
        run_sched(32'h0, 32'h1, 1'b1, EXP_CYC);

        toggle_en = 1'b1;
        run_sched(32'h1, 32'h1, 1'b0, 0);
        toggle_en = 1'b0;

        // Start/seed pulse at slot 10 must be ignored; reset at slot 20 aborts.
        gen_expected(32'h1);
        seed_i = 32'h1;
        seed_load_i = 1'b1;
        start_i = 1'b1;
        base = hs_count;
        done_before = done_cnt;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seed_load_i = 1'b0;
        for (int i = 0; i < 2000 && hs_count < base + 10; i++) @(negedge clk);
        chk("reach_slot10", 32'(hs_count - base), 32'd10);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        seed_i = 32'h2;
        seed_load_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        seed_load_i = 1'b0;
        for (int i = 0; i < 2000 && hs_count < base + 20; i++) @(negedge clk);
        chk("reach_slot20", 32'(hs_count - base), 32'd20);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        valid_before = valid_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_valid", 32'(valid_cnt - valid_before), 32'd0);
        chk("abort_no_done", 32'(done_cnt - done_before), 32'd0);
        chk("abort_idle_busy", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
